// File: rtl/ram_arb_pkg.sv
// Shared types for the RAM arbiter: FSM state encoding and grant indices.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam logic GNT_A = 1'b0;
  localparam logic GNT_B = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick. Purely combinational; the caller owns `last`.
// Ports:
//   a_req_i, b_req_i : request lines
//   last_i           : requester granted most recently (GNT_A / GNT_B)
//   valid_o          : at least one request present
//   gnt_o            : winner (GNT_A / GNT_B)
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic a_req_i,
  input  logic b_req_i,
  input  logic last_i,
  output logic valid_o,
  output logic gnt_o
);

  always_comb begin
    valid_o = a_req_i | b_req_i;
    gnt_o   = GNT_A;
    if (a_req_i && b_req_i) begin
      // Tie: whoever was not served last wins.
      gnt_o = (last_i == GNT_A) ? GNT_B : GNT_A;
    end else if (b_req_i) begin
      gnt_o = GNT_B;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester arbiter and access sequencer for a single-port RAM with
// synchronous write and combinational read. Each access takes three cycles:
// IDLE (grant + latch) -> ACCESS (drive RAM) -> DONE (ack).
// Ports:
//   clk, reset                   : clock, async active-high reset
//   a_req/a_we/a_addr/a_wdata    : requester A access request
//   a_ack/a_rdata                : A completion pulse and read result
//   b_*                          : same for requester B
//   ram_load/ram_address/ram_in  : drive the RAM write/address/data pins
//   ram_out                      : RAM combinational read data
//   err                          : pulses with ack on an out-of-range address
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 15,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [WIDTH-1:0]  a_wdata,
  output logic              a_ack,
  output logic [WIDTH-1:0]  a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [WIDTH-1:0]  b_wdata,
  output logic              b_ack,
  output logic [WIDTH-1:0]  b_rdata,
  output logic              ram_load,
  output logic [ADDR_W-1:0] ram_address,
  output logic [WIDTH-1:0]  ram_in,
  input  logic [WIDTH-1:0]  ram_out,
  output logic              err
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  state_e              state_q;
  logic                gnt_q, last_q, we_q, oor_q;
  logic                a_ack_q, b_ack_q, err_q, ram_load_q;
  logic [ADDR_W-1:0]   ram_address_q;
  logic [WIDTH-1:0]    ram_in_q, a_rdata_q, b_rdata_q;

  logic                arb_valid, gnt_d;
  logic                we_d, oor_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [WIDTH-1:0]    wdata_d;

  rr_arb2 u_rr (
    .a_req_i (a_req),
    .b_req_i (b_req),
    .last_i  (last_q),
    .valid_o (arb_valid),
    .gnt_o   (gnt_d)
  );

  // Mux the winner's request fields; only consumed in IDLE.
  always_comb begin
    we_d    = a_we;
    addr_d  = a_addr;
    wdata_d = a_wdata;
    if (gnt_d == GNT_B) begin
      we_d    = b_we;
      addr_d  = b_addr;
      wdata_d = b_wdata;
    end
    oor_d = ({1'b0, addr_d} >= DEPTH_L);
  end

  // The RAM pins double as the access latch: they are loaded on grant and
  // cleared leaving ACCESS, so they are non-zero only during ACCESS.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      gnt_q         <= GNT_A;
      last_q        <= GNT_B;
      we_q          <= 1'b0;
      oor_q         <= 1'b0;
      a_ack_q       <= 1'b0;
      b_ack_q       <= 1'b0;
      err_q         <= 1'b0;
      ram_load_q    <= 1'b0;
      ram_address_q <= '0;
      ram_in_q      <= '0;
      a_rdata_q     <= '0;
      b_rdata_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arb_valid) begin
            gnt_q         <= gnt_d;
            last_q        <= gnt_d;
            we_q          <= we_d;
            oor_q         <= oor_d;
            ram_load_q    <= we_d & ~oor_d;
            ram_address_q <= addr_d;
            ram_in_q      <= wdata_d;
            state_q       <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (!we_q) begin
            if (gnt_q == GNT_A) a_rdata_q <= oor_q ? '0 : ram_out;
            else                b_rdata_q <= oor_q ? '0 : ram_out;
          end
          ram_load_q    <= 1'b0;
          ram_address_q <= '0;
          ram_in_q      <= '0;
          a_ack_q       <= (gnt_q == GNT_A);
          b_ack_q       <= (gnt_q == GNT_B);
          err_q         <= oor_q;
          state_q       <= ST_DONE;
        end
        ST_DONE: begin
          a_ack_q <= 1'b0;
          b_ack_q <= 1'b0;
          err_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign a_ack       = a_ack_q;
  assign b_ack       = b_ack_q;
  assign a_rdata     = a_rdata_q;
  assign b_rdata     = b_rdata_q;
  assign err         = err_q;
  assign ram_load    = ram_load_q;
  assign ram_address = ram_address_q;
  assign ram_in      = ram_in_q;

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_req, a_we, b_req, b_we;
  logic [3:0]  a_addr, b_addr;
  logic [15:0] a_wdata, b_wdata;
  logic        a_ack, b_ack, ram_load, err;
  logic [15:0] a_rdata, b_rdata, ram_in, ram_out;
  logic [3:0]  ram_address;
  logic        ram_init;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.WIDTH(16), .DEPTH(15)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .ram_load(ram_load), .ram_address(ram_address), .ram_in(ram_in),
    .ram_out(ram_out), .err(err)
  );

  // RAM model: 15 words, synchronous write, combinational read.
  // Out-of-range reads return a junk pattern the arbiter must mask to 0.
  logic [15:0] mem [0:14];
  assign ram_out = (ram_address < 4'd15) ? mem[ram_address] : 16'hDEAD;
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 15; i++) mem[i] <= 16'h0000;
      mem[5] <= 16'h00AA;
    end else if (ram_load && ram_address < 4'd15) begin
      mem[ram_address] <= ram_in;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One uncontended access, started from IDLE.
  task automatic do_access(input string tag, input logic is_b, input logic we,
                           input logic [3:0] addr, input logic [15:0] wd,
                           input logic [15:0] exp_rd, input logic exp_load,
                           input logic exp_err);
    if (is_b) begin b_req = 1; b_we = we; b_addr = addr; b_wdata = wd; end
    else      begin a_req = 1; a_we = we; a_addr = addr; a_wdata = wd; end
    tick();
    chk({tag, ".acc_load"}, 32'(ram_load), 32'(exp_load));
    chk({tag, ".acc_addr"}, 32'(ram_address), 32'(addr));
    chk({tag, ".acc_in"}, 32'(ram_in), 32'(wd));
    chk({tag, ".acc_noack"}, 32'({a_ack, b_ack}), 32'd0);
    tick();
    chk({tag, ".ack"}, 32'({a_ack, b_ack}), is_b ? 32'd1 : 32'd2);
    chk({tag, ".err"}, 32'(err), 32'(exp_err));
    chk({tag, ".done_load"}, 32'(ram_load), 32'd0);
    chk({tag, ".rdata"}, 32'(is_b ? b_rdata : a_rdata), 32'(exp_rd));
    a_req = 0; b_req = 0;
    tick();
    chk({tag, ".idle_ack"}, 32'({a_ack, b_ack, err}), 32'd0);
  endtask

  initial begin
    reset = 1; ram_init = 1;
    a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
    tick(); tick();
    chk("rst.outs", 32'({a_ack, b_ack, ram_load, err}), 32'd0);
    chk("rst.addr", 32'(ram_address), 32'd0);
    chk("rst.in", 32'(ram_in), 32'd0);
    chk("rst.rdata", {a_rdata, b_rdata}, 32'd0);
    ram_init = 0; reset = 0;
    tick();

    do_access("a_wr3", 1'b0, 1'b1, 4'd3, 16'h1234, 16'h0000, 1'b1, 1'b0);
    do_access("a_rd3", 1'b0, 1'b0, 4'd3, 16'h0000, 16'h1234, 1'b0, 1'b0);
    do_access("b_rd5", 1'b1, 1'b0, 4'd5, 16'h0000, 16'h00AA, 1'b0, 1'b0);
    do_access("b_wr6", 1'b1, 1'b1, 4'd6, 16'h5555, 16'h00AA, 1'b1, 1'b0);

    // Both held: last grant was B, so order is A,B,A,B,...
    a_req = 1; a_we = 0; a_addr = 4'd3;
    b_req = 1; b_we = 0; b_addr = 4'd6;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("tie.acc_addr", 32'(ram_address), (i % 2 == 0) ? 32'd3 : 32'd6);
      chk("tie.acc_noack", 32'({a_ack, b_ack}), 32'd0);
      tick();
      chk("tie.ack", 32'({a_ack, b_ack}), (i % 2 == 0) ? 32'd2 : 32'd1);
      chk("tie.rdata", (i % 2 == 0) ? 32'(a_rdata) : 32'(b_rdata),
          (i % 2 == 0) ? 32'h1234 : 32'h5555);
      if (i == 7) begin a_req = 0; b_req = 0; end
      tick();
      chk("tie.idle_noack", 32'({a_ack, b_ack}), 32'd0);
    end

    // B writes 14 while A starts waiting to read 14.
    b_req = 1; b_we = 1; b_addr = 4'd14; b_wdata = 16'hBEEF;
    tick();
    chk("bw14.acc", 32'({ram_load, ram_address}), 32'h1E);
    a_req = 1; a_we = 0; a_addr = 4'd14;
    tick();
    chk("bw14.ack", 32'({a_ack, b_ack}), 32'd1);
    b_req = 0;
    tick();
    chk("bw14.idle", 32'({a_ack, b_ack, ram_load}), 32'd0);
    tick();
    chk("ar14.acc", 32'({ram_load, ram_address}), 32'h0E);
    tick();
    chk("ar14.ack", 32'({a_ack, b_ack}), 32'd2);
    chk("ar14.rdata", 32'(a_rdata), 32'hBEEF);
    a_req = 0;
    tick();

    do_access("a_wr15", 1'b0, 1'b1, 4'd15, 16'hFFFF, 16'hBEEF, 1'b0, 1'b1);
    do_access("a_rd15", 1'b0, 1'b0, 4'd15, 16'h0000, 16'h0000, 1'b0, 1'b1);

    // Reset during the ACCESS of an A write.
    a_req = 1; a_we = 1; a_addr = 4'd7; a_wdata = 16'h7777;
    tick();
    chk("rstmid.acc_load", 32'(ram_load), 32'd1);
    #2 reset = 1;
    #1;
    chk("rstmid.load", 32'(ram_load), 32'd0);
    chk("rstmid.addr_in", {16'(ram_address), ram_in}, 32'd0);
    a_req = 0;
    tick();
    chk("rstmid.noack", 32'({a_ack, b_ack, err}), 32'd0);
    chk("rstmid.rdata", {a_rdata, b_rdata}, 32'd0);
    reset = 0;
    a_req = 1; a_we = 1; a_addr = 4'd7; a_wdata = 16'h7777;
    b_req = 1; b_we = 0; b_addr = 4'd7;
    tick();
    chk("post.acc_a", 32'({ram_load, ram_address}), 32'h17);
    tick();
    chk("post.ack_a", 32'({a_ack, b_ack}), 32'd2);
    a_req = 0;
    tick();
    tick();
    chk("post.acc_b", 32'({ram_load, ram_address}), 32'h07);
    tick();
    chk("post.ack_b", 32'({a_ack, b_ack}), 32'd1);
    chk("post.rdata_b", 32'(b_rdata), 32'h7777);
    b_req = 0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
